ram_fifo_ctrl: RTL and testbench



---
 rtl/ram_fifo_ctrl_pkg.sv | 14 +
 rtl/ram_fifo_ctrl_if.sv | 24 ++
 rtl/ram_fifo_obuf.sv | 41 ++++
 rtl/ram_fifo_ctrl.sv | 101 ++++++++++
 tb/tb_ram_fifo_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ram_fifo_ctrl_pkg.sv
// RAM geometry and enable encodings shared by the FIFO controller, its output buffer and the bench.
package qlf_fifo_pkg;

  localparam int RAM_DATA_W = 32;
  localparam int RAM_ADDR_W = 9;
  localparam int RAM_DEPTH  = 512;

  // DP_RAM16K enables are active low
  localparam logic RAM_EN  = 1'b0;
  localparam logic RAM_DIS = 1'b1;

  typedef logic [RAM_ADDR_W-1:0] ram_addr_t;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Producer/consumer stream bundle of the RAM FIFO plus its fill-level status.
interface ram_fifo_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) ();
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W+1:0] level;
  logic              almost_full;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, level, almost_full
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, level, almost_full
  );
endinterface

// File: rtl/ram_fifo_obuf.sv
// Two-entry output buffer that absorbs RAM read returns; head visible combinationally from registers.
module ram_fifo_obuf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_dat,
  input  logic              i_pop,
  output logic [1:0]        o_cnt,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_head
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_rd_idx;
  logic [1:0]        r_cnt;
  logic              w_wr_idx;

  // A load never arrives while both slots are full, so the slot after the head is always free.
  assign w_wr_idx = r_rd_idx ^ r_cnt[0];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_rd_idx <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_pop) r_rd_idx <= ~r_rd_idx;
      r_cnt <= r_cnt + {1'b0, i_load} - {1'b0, i_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (i_load && !i_clr) r_mem[w_wr_idx] <= i_load_dat;
  end

  assign o_cnt  = r_cnt;
  assign o_vld  = (r_cnt != 2'd0);
  assign o_head = r_mem[r_rd_idx];

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO over one DP_RAM16K: pointers, occupancy, read issue; 3-cycle empty-FIFO latency.
// Define QLF_FIFO_FLUSH_EN to add a synchronous `flush` input that clears FIFO state like R.
module ram_fifo_ctrl
  import qlf_fifo_pkg::*;
#(
  parameter int DATA_W   = RAM_DATA_W,
  parameter int ADDR_W   = RAM_ADDR_W,
  parameter int DEPTH    = RAM_DEPTH,
  parameter int AFULL_TH = 480
) (
  input  logic              clk,
  input  logic              R,
`ifdef QLF_FIFO_FLUSH_EN
  input  logic              flush,
`endif
  ram_fifo_ctrl_if.slave    s_if,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_d_in,
  output logic [DATA_W-1:0] ram_wenb,
  output logic              ram_ren,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_d_out
);

  localparam logic [ADDR_W:0]   L_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] L_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W+1:0] L_AFULL = (ADDR_W+2)'(AFULL_TH);

  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_ram_cnt;
  logic              r_inflight;
  logic [ADDR_W+1:0] r_level;

  logic              w_clr;
  logic              w_push;
  logic              w_pop;
  logic              w_issue;
  logic [2:0]        w_occ;
  logic [1:0]        w_obuf_cnt;
  logic              w_obuf_vld;
  logic [DATA_W-1:0] w_obuf_head;

`ifdef QLF_FIFO_FLUSH_EN
  assign w_clr = R | flush;
`else
  assign w_clr = R;
`endif

  assign s_if.in_ready = (r_ram_cnt < L_DEPTH);

  assign w_push = s_if.in_valid & s_if.in_ready & ~w_clr;
  assign w_pop  = w_obuf_vld & s_if.out_ready & ~w_clr;

  // Registered ram_cnt keeps a word written this cycle from being read this cycle.
  assign w_occ   = {1'b0, w_obuf_cnt} + {2'b00, r_inflight};
  assign w_issue = (r_ram_cnt != '0) && (w_occ < (3'd2 + {2'b00, w_pop})) && !w_clr;

  assign ram_wen   = w_push ? RAM_EN : RAM_DIS;
  assign ram_waddr = r_wptr;
  assign ram_d_in  = s_if.in_data;
  assign ram_wenb  = '1;
  assign ram_ren   = w_issue ? RAM_EN : RAM_DIS;
  assign ram_raddr = r_rptr;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
      r_level    <= '0;
    end else begin
      if (w_push)  r_wptr <= (r_wptr == L_LAST) ? '0 : r_wptr + 1'b1;
      if (w_issue) r_rptr <= (r_rptr == L_LAST) ? '0 : r_rptr + 1'b1;
      r_ram_cnt  <= r_ram_cnt + {{ADDR_W{1'b0}}, w_push} - {{ADDR_W{1'b0}}, w_issue};
      r_inflight <= w_issue;
      r_level    <= r_level + {{(ADDR_W+1){1'b0}}, w_push} - {{(ADDR_W+1){1'b0}}, w_pop};
    end
  end

  ram_fifo_obuf #(
    .DATA_W (DATA_W)
  ) u_obuf (
    .clk        (clk),
    .i_clr      (w_clr),
    .i_load     (r_inflight),
    .i_load_dat (ram_d_out),
    .i_pop      (w_pop),
    .o_cnt      (w_obuf_cnt),
    .o_vld      (w_obuf_vld),
    .o_head     (w_obuf_head)
  );

  assign s_if.out_data    = w_obuf_head;
  assign s_if.out_valid   = w_obuf_vld;
  assign s_if.level       = r_level;
  assign s_if.almost_full = (r_level >= L_AFULL);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a behavioural DP_RAM16K and a queue reference model.
module tb_ram_fifo_ctrl;
  import qlf_fifo_pkg::*;

  localparam int DW       = 32;
  localparam int AW       = 9;
  localparam int DEPTH    = 512;
  localparam int AFULL_TH = 480;

  logic clk = 1'b0;
  logic R;
`ifdef QLF_FIFO_FLUSH_EN
  logic flush;
`endif

  always #5 clk = ~clk;

  ram_fifo_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) s_if ();

  logic          ram_wen, ram_ren;
  ram_addr_t     ram_waddr, ram_raddr;
  logic [DW-1:0] ram_d_in, ram_wenb, ram_d_out;

  ram_fifo_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)
  ) dut (
    .clk       (clk),
    .R         (R),
`ifdef QLF_FIFO_FLUSH_EN
    .flush     (flush),
`endif
    .s_if      (s_if.slave),
    .ram_wen   (ram_wen),
    .ram_waddr (ram_waddr),
    .ram_d_in  (ram_d_in),
    .ram_wenb  (ram_wenb),
    .ram_ren   (ram_ren),
    .ram_raddr (ram_raddr),
    .ram_d_out (ram_d_out)
  );

  // Behavioural DP_RAM16K: registered read, read-before-write on collision.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wen == RAM_EN) mem[ram_waddr] <= (mem[ram_waddr] & ~ram_wenb) | (ram_d_in & ram_wenb);
    if (ram_ren == RAM_EN) ram_d_out <= mem[ram_raddr];
  end

  int            n_chk  = 0;
  int            n_pass = 0;
  logic [DW-1:0] q [$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  task automatic do_reset();
    R = 1'b1;
`ifdef QLF_FIFO_FLUSH_EN
    flush = 1'b0;
`endif
    s_if.in_valid  = 1'b1;
    s_if.in_data   = 32'hBAD0_0000;
    s_if.out_ready = 1'b1;
    #1;
    chk("rst_wen", 64'(ram_wen), 64'(1));
    chk("rst_ren", 64'(ram_ren), 64'(1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    R = 1'b0;
    s_if.in_valid  = 1'b0;
    s_if.out_ready = 1'b0;
    q.delete();
  endtask

  // One cycle, entered and left at posedge+1; compares the DUT against the queue model.
  task automatic run_cyc(input logic iv, input logic [DW-1:0] id, input logic ordy,
                         output logic pushed, output logic popped);
    s_if.in_valid  = iv;
    s_if.in_data   = id;
    s_if.out_ready = ordy;
    #1;
    chk("level", 64'(s_if.level), 64'(q.size()));
    chk("almost_full", 64'(s_if.almost_full), 64'(q.size() >= AFULL_TH));
    if (q.size() < DEPTH)     chk("in_ready_room", 64'(s_if.in_ready), 64'(1));
    if (q.size() == DEPTH + 2) chk("in_ready_full", 64'(s_if.in_ready), 64'(0));
    if (q.size() == 0)        chk("empty_valid", 64'(s_if.out_valid), 64'(0));
    else if (s_if.out_valid)  chk("out_data", 64'(s_if.out_data), 64'(q[0]));
    pushed = s_if.in_valid & s_if.in_ready;
    popped = s_if.out_valid & s_if.out_ready;
    if (pushed) q.push_back(id);
    if (popped && q.size() != 0) void'(q.pop_front());
    @(posedge clk); #1;
  endtask

  task automatic fill_to(input int n, input int base);
    int   k = 0;
    logic p, o;
    for (int c = 0; c < 700 && k < n; c++) begin
      run_cyc(1'b1, DW'(base + k), 1'b0, p, o);
      if (p) k++;
    end
    chk("fill_count", 64'(k), 64'(n));
  endtask

  task automatic drain();
    logic p, o;
    for (int c = 0; c < 1200 && q.size() != 0; c++) run_cyc(1'b0, '0, 1'b1, p, o);
    chk("drain_done", 64'(q.size()), 64'(0));
    for (int c = 0; c < 3; c++) run_cyc(1'b0, '0, 1'b1, p, o);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic p, o;
    int   npush, npop;

    // Reset state and single-word latency
    do_reset();
    s_if.in_valid = 1'b1;
    s_if.in_data  = 32'hDEADBEEF;
    #1;
    chk("rst_out_valid", 64'(s_if.out_valid), 64'(0));
    chk("rst_level", 64'(s_if.level), 64'(0));
    chk("rst_afull", 64'(s_if.almost_full), 64'(0));
    chk("rst_in_ready", 64'(s_if.in_ready), 64'(1));
    chk("c0_wen", 64'(ram_wen), 64'(0));
    chk("c0_waddr", 64'(ram_waddr), 64'(0));
    chk("c0_d_in", 64'(ram_d_in), 64'(32'hDEADBEEF));
    @(posedge clk); #1;
    s_if.in_valid = 1'b0;
    #1;
    chk("c1_ren", 64'(ram_ren), 64'(0));
    chk("c1_raddr", 64'(ram_raddr), 64'(0));
    chk("c1_out_valid", 64'(s_if.out_valid), 64'(0));
    chk("c1_level", 64'(s_if.level), 64'(1));
    @(posedge clk); #2;
    chk("c2_out_valid", 64'(s_if.out_valid), 64'(0));
    @(posedge clk); #2;
    chk("c3_out_valid", 64'(s_if.out_valid), 64'(1));
    chk("c3_out_data", 64'(s_if.out_data), 64'(32'hDEADBEEF));
    chk("c3_level", 64'(s_if.level), 64'(1));
    s_if.out_ready = 1'b1;
    @(posedge clk); #1;
    s_if.out_ready = 1'b0;
    #1;
    chk("c4_out_valid", 64'(s_if.out_valid), 64'(0));
    chk("c4_level", 64'(s_if.level), 64'(0));

    // Fill to DEPTH+2 with consumer stalled, then drain in order
    do_reset();
    fill_to(DEPTH + 2, 0);
    for (int c = 0; c < 4; c++) run_cyc(1'b1, 32'hFFFF_FFFF, 1'b0, p, o);
    chk("full_level", 64'(s_if.level), 64'(DEPTH + 2));
    drain();

    // Continuous streaming across pointer wrap
    do_reset();
    npush = 0;
    npop  = 0;
    for (int c = 0; c < 2000; c++) begin
      run_cyc(1'b1, DW'(npush), 1'b1, p, o);
      if (p) npush++;
      if (o) npop++;
    end
    chk("stream_pushes", 64'(npush), 64'(2000));
    chk("stream_pops", 64'(npop), 64'(1997));
    drain();

    // Random traffic against the reference queue
    do_reset();
    for (int c = 0; c < 10000; c++)
      run_cyc(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), p, o);
    drain();

    // Reset with a read in flight; stale data must not surface
    do_reset();
    fill_to(301, 1000);
    for (int c = 0; c < 3; c++) run_cyc(1'b0, '0, 1'b0, p, o);
    run_cyc(1'b0, '0, 1'b1, p, o);
    chk("pre_rst_pop", 64'(o), 64'(1));
    R = 1'b1;
    s_if.in_valid  = 1'b0;
    s_if.out_ready = 1'b1;
    #1;
    chk("pre_rst_level", 64'(s_if.level), 64'(300));
    chk("midrst_ren", 64'(ram_ren), 64'(1));
    @(posedge clk); #1;
    R = 1'b0;
    q.delete();
    #1;
    chk("post_rst_valid", 64'(s_if.out_valid), 64'(0));
    chk("post_rst_level", 64'(s_if.level), 64'(0));
    chk("post_rst_in_ready", 64'(s_if.in_ready), 64'(1));
    @(posedge clk); #1;
    run_cyc(1'b1, 32'h1, 1'b1, p, o);
    npop = 0;
    for (int c = 0; c < 8; c++) begin
      run_cyc(1'b0, '0, 1'b1, p, o);
      if (o) npop++;
    end
    chk("post_rst_pops", 64'(npop), 64'(1));

`ifdef QLF_FIFO_FLUSH_EN
    // Flush concurrent with push and pop
    do_reset();
    fill_to(10, 500);
    for (int c = 0; c < 3; c++) run_cyc(1'b0, '0, 1'b0, p, o);
    flush          = 1'b1;
    s_if.in_valid  = 1'b1;
    s_if.in_data   = 32'h5555_AAAA;
    s_if.out_ready = 1'b1;
    #1;
    chk("flush_wen", 64'(ram_wen), 64'(1));
    chk("flush_ren", 64'(ram_ren), 64'(1));
    @(posedge clk); #1;
    flush = 1'b0;
    q.delete();
    for (int c = 0; c < 3; c++) run_cyc(1'b0, '0, 1'b1, p, o);
    run_cyc(1'b1, 32'h77, 1'b1, p, o);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
